// File: rtl/uvmt_cv32e40x_obi_arbiter.sv
// 2:1 OBI arbiter: two core masters share one slave port.
// Responses return in order via an owner-ID FIFO.
module uvmt_cv32e40x_obi_arbiter #(
  parameter int APAYLOAD_W      = 75,
  parameter int RPAYLOAD_W      = 39,
  parameter int MAX_OUTSTANDING = 2,
  parameter int FIXED_PRIO      = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m0_req_i,
  output logic                  m0_gnt_o,
  input  logic [APAYLOAD_W-1:0] m0_apayload_i,
  output logic                  m0_rvalid_o,
  input  logic                  m1_req_i,
  output logic                  m1_gnt_o,
  input  logic [APAYLOAD_W-1:0] m1_apayload_i,
  output logic                  m1_rvalid_o,
  output logic [RPAYLOAD_W-1:0] m_rpayload_o,
  output logic                  s_req_o,
  input  logic                  s_gnt_i,
  output logic [APAYLOAD_W-1:0] s_apayload_o,
  input  logic                  s_rvalid_i,
  input  logic [RPAYLOAD_W-1:0] s_rpayload_i,
  output logic [1:0]            err_o
);

  localparam int PW = (MAX_OUTSTANDING > 1) ?
                      $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] MAX_C  = CW'(MAX_OUTSTANDING);
  localparam logic [PW-1:0] LAST_P = PW'(MAX_OUTSTANDING - 1);

  typedef enum logic {UNLOCKED, LOCKED} lock_e;

  lock_e                      lock_q;
  logic                       owner_q;
  logic                       rr_last_q;
  logic [MAX_OUTSTANDING-1:0] fifo_q;
  logic [PW-1:0]              wr_q;
  logic [PW-1:0]              rd_q;
  logic [CW-1:0]              cnt_q;
  logic [1:0]                 err_q;

  logic owner;
  logic tie_pick;
  logic owner_req;
  logic push;
  logic pop;
  logic head;
  logic retract;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == LAST_P) ? '0 : p + 1'b1;
  endfunction

  assign tie_pick = (FIXED_PRIO != 0) ? 1'b1 : ~rr_last_q;

  always_comb begin
    owner = owner_q;
    if (lock_q == UNLOCKED) begin
      unique case (1'b1)
        m0_req_i && m1_req_i:  owner = tie_pick;
        m0_req_i && !m1_req_i: owner = 1'b0;
        !m0_req_i && m1_req_i: owner = 1'b1;
        default:               owner = owner_q;
      endcase
    end
  end

  assign owner_req    = owner ? m1_req_i : m0_req_i;
  // A pop in the same cycle does not free a slot for the request.
  assign s_req_o      = owner_req && (cnt_q < MAX_C);
  assign s_apayload_o = owner ? m1_apayload_i : m0_apayload_i;
  assign push         = s_req_o && s_gnt_i;
  assign m0_gnt_o     = push && !owner;
  assign m1_gnt_o     = push && owner;

  assign head         = fifo_q[rd_q];
  assign pop          = s_rvalid_i && (cnt_q != '0);
  assign m0_rvalid_o  = pop && !head;
  assign m1_rvalid_o  = pop && head;
  assign m_rpayload_o = s_rpayload_i;
  assign retract      = (lock_q == LOCKED) && !owner_req;
  assign err_o        = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q    <= UNLOCKED;
      owner_q   <= 1'b0;
      rr_last_q <= 1'b1;
      fifo_q    <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      err_q     <= '0;
    end else begin
      owner_q <= owner;
      unique case (lock_q)
        UNLOCKED: begin
          if (s_req_o && !s_gnt_i) lock_q <= LOCKED;
        end
        LOCKED: begin
          if (retract) begin
            lock_q   <= UNLOCKED;
            err_q[1] <= 1'b1;
          end else if (push) begin
            lock_q <= UNLOCKED;
          end
        end
      endcase
      if (s_rvalid_i && (cnt_q == '0)) err_q[0] <= 1'b1;
      if (push) begin
        fifo_q[wr_q] <= owner;
        wr_q         <= nxt(wr_q);
        rr_last_q    <= owner;
      end
      if (pop) rd_q <= nxt(rd_q);
      if (push && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (pop && !push) cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: tb/tb_uvmt_cv32e40x_obi_arbiter.sv
// Bench for uvmt_cv32e40x_obi_arbiter: directed cases plus
// random traffic checked every cycle against a queue model.
module tb_uvmt_cv32e40x_obi_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_req = 0, m1_req = 0, s_gnt = 0, s_rvalid = 0;
  logic [74:0] m0_ap = '0, m1_ap = '0;
  logic [38:0] s_rp = '0;
  logic        m0_gnt, m1_gnt, m0_rv, m1_rv, s_req;
  logic [38:0] m_rp;
  logic [74:0] s_ap;
  logic [1:0]  err;

  logic        f_m0_req = 0, f_m1_req = 0, f_gnt = 0, f_rv = 0;
  logic [74:0] f_ap0 = '0, f_ap1 = '0;
  logic [38:0] f_rpi = '0;
  logic        f_m0_gnt, f_m1_gnt, f_m0_rv, f_m1_rv, f_s_req;
  logic [38:0] f_rp;
  logic [74:0] f_s_ap;
  logic [1:0]  f_err;
  bit          fen = 0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  uvmt_cv32e40x_obi_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req_i(m0_req), .m0_gnt_o(m0_gnt),
    .m0_apayload_i(m0_ap), .m0_rvalid_o(m0_rv),
    .m1_req_i(m1_req), .m1_gnt_o(m1_gnt),
    .m1_apayload_i(m1_ap), .m1_rvalid_o(m1_rv),
    .m_rpayload_o(m_rp), .s_req_o(s_req),
    .s_gnt_i(s_gnt), .s_apayload_o(s_ap),
    .s_rvalid_i(s_rvalid), .s_rpayload_i(s_rp),
    .err_o(err)
  );

  uvmt_cv32e40x_obi_arbiter #(.FIXED_PRIO(1)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .m0_req_i(f_m0_req), .m0_gnt_o(f_m0_gnt),
    .m0_apayload_i(f_ap0), .m0_rvalid_o(f_m0_rv),
    .m1_req_i(f_m1_req), .m1_gnt_o(f_m1_gnt),
    .m1_apayload_i(f_ap1), .m1_rvalid_o(f_m1_rv),
    .m_rpayload_o(f_rp), .s_req_o(f_s_req),
    .s_gnt_i(f_gnt), .s_apayload_o(f_s_ap),
    .s_rvalid_i(f_rv), .s_rpayload_i(f_rpi),
    .err_o(f_err)
  );

  task automatic chk(string n, logic [127:0] a,
                     logic [127:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", n, a, e, $time);
    end
  endtask

  // Reference model: queue of owner IDs plus arbitration rules.
  bit       q[$];
  bit       lk, own, rrl;
  bit [1:0] er;
  bit       e_g0, e_g1;

  initial begin
    bit o, oreq, sreq, pp, hd;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete();
        lk = 0; own = 0; rrl = 1; er = 0;
      end
      if (lk) o = own;
      else if (m0_req && m1_req) o = !rrl;
      else if (m0_req) o = 0;
      else if (m1_req) o = 1;
      else o = own;
      oreq = o ? m1_req : m0_req;
      sreq = oreq && (q.size() < 2);
      pp   = s_rvalid && (q.size() > 0);
      hd   = pp ? q[0] : 1'b0;
      e_g0 = sreq && s_gnt && !o;
      e_g1 = sreq && s_gnt && o;
      chk("m_s_req", s_req, sreq);
      chk("m_gnt0", m0_gnt, e_g0);
      chk("m_gnt1", m1_gnt, e_g1);
      chk("m_rv0", m0_rv, pp && !hd);
      chk("m_rv1", m1_rv, pp && hd);
      chk("m_err", err, er);
      if (sreq) chk("m_s_ap", s_ap, o ? m1_ap : m0_ap);
      if (pp) chk("m_rpay", m_rp, s_rp);
      if (rst_n) begin
        if (lk && !oreq) begin lk = 0; er[1] = 1; end
        else if (!lk && sreq && !s_gnt) lk = 1;
        else if (lk && sreq && s_gnt) lk = 0;
        own = o;
        if (s_rvalid && q.size() == 0) er[0] = 1;
        if (pp) void'(q.pop_front());
        if (sreq && s_gnt) begin q.push_back(o); rrl = o; end
      end
    end
  end

  task automatic step(bit r0, bit r1, bit g, bit rv,
                      logic [38:0] rp = '0);
    @(posedge clk); #1;
    m0_req = r0; m1_req = r1; s_gnt = g;
    s_rvalid = rv; s_rp = rp;
    f_m0_req = fen; f_m1_req = fen;
    f_gnt = fen; f_rv = fen && rv;
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    m0_req = 0; m1_req = 0; s_gnt = 0; s_rvalid = 0;
    rst_n = 0; #1;
    chk("rst_s_req", s_req, 0);
    chk("rst_gnt", {m0_gnt, m1_gnt}, 0);
    chk("rst_rv", {m0_rv, m1_rv}, 0);
    chk("rst_err", err, 0);
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  function automatic logic [74:0] rnd_ap();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[74:0];
  endfunction

  localparam logic [74:0] P0 = 75'h0_1111_2222_3333_4444;
  localparam logic [74:0] P1 = 75'h5_AAAA_BBBB_CCCC_DDDD;

  initial begin
    m0_ap = P0; m1_ap = P1;
    do_reset();

    step(1, 0, 1, 0);
    chk("t1_gnt0", m0_gnt, 1);
    chk("t1_gnt1", m1_gnt, 0);
    chk("t1_ap", s_ap, P0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1, 39'h12_3456_789A);
    chk("t1_rv0", m0_rv, 1);
    chk("t1_rv1", m1_rv, 0);
    chk("t1_rpay", m_rp, 39'h12_3456_789A);

    do_reset();
    fen = 1;
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 1, i > 0, 39'(i));
      chk("t2_gnt0", m0_gnt, (i % 2) == 0);
      chk("t2_gnt1", m1_gnt, (i % 2) == 1);
      if (i > 0) chk("t2_rv0", m0_rv, ((i - 1) % 2) == 0);
      chk("t2_fp_gnt1", f_m1_gnt, 1);
      chk("t2_fp_gnt0", f_m0_gnt, 0);
    end
    fen = 0;

    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, 0);
      chk("t3_hold_ap", s_ap, P0);
      chk("t3_nogrant", {m0_gnt, m1_gnt}, 0);
    end
    step(1, 1, 1, 0);
    chk("t3_gnt0", m0_gnt, 1);
    chk("t3_ap", s_ap, P0);
    step(0, 1, 1, 0);
    chk("t3_gnt1", m1_gnt, 1);

    step(1, 0, 1, 0);
    chk("t4_full_req", s_req, 0);
    chk("t4_full_gnt", m0_gnt, 0);
    step(1, 0, 1, 1, 39'h7);
    chk("t4_pop_req", s_req, 0);
    chk("t4_pop_rv0", m0_rv, 1);
    step(1, 0, 1, 0);
    chk("t4_reassert", s_req, 1);
    chk("t4_gnt0", m0_gnt, 1);

    do_reset();
    step(0, 1, 1, 0);
    chk("t5_g1", m1_gnt, 1);
    step(1, 0, 1, 0);
    chk("t5_g2", m0_gnt, 1);
    step(0, 0, 0, 1, 39'h11_1111_1111);
    chk("t5_r1", {m0_rv, m1_rv}, 2'b01);
    chk("t5_r1_pay", m_rp, 39'h11_1111_1111);
    step(0, 1, 1, 0);
    chk("t5_g3", m1_gnt, 1);
    step(0, 0, 0, 1, 39'h22_2222_2222);
    chk("t5_r2", {m0_rv, m1_rv}, 2'b10);
    chk("t5_r2_pay", m_rp, 39'h22_2222_2222);
    step(0, 0, 0, 1, 39'h33_3333_3333);
    chk("t5_r3", {m0_rv, m1_rv}, 2'b01);
    chk("t5_r3_pay", m_rp, 39'h33_3333_3333);

    step(1, 0, 1, 1, 39'h5);
    chk("t6_push_gnt", m0_gnt, 1);
    chk("t6_empty_rv", {m0_rv, m1_rv}, 0);
    step(0, 1, 0, 0);
    chk("t6_err01", err, 2'b01);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("t6_err11", err, 2'b11);
    do_reset();

    for (int c = 0; c < 3000; c++) begin
      if (c % 700 == 699) begin
        do_reset();
        continue;
      end
      @(posedge clk); #1;
      if (!(m0_req && !e_g0 && $urandom_range(0, 19) != 0)) begin
        m0_req = $urandom_range(0, 99) < 55;
        m0_ap  = rnd_ap();
      end
      if (!(m1_req && !e_g1 && $urandom_range(0, 19) != 0)) begin
        m1_req = $urandom_range(0, 99) < 55;
        m1_ap  = rnd_ap();
      end
      s_gnt = $urandom_range(0, 9) < 7;
      if (q.size() > 0) s_rvalid = $urandom_range(0, 1) == 1;
      else s_rvalid = $urandom_range(0, 29) == 0;
      s_rp = 39'({$urandom, $urandom});
    end

    @(posedge clk); #1;
    m0_req = 0; m1_req = 0; s_gnt = 0; s_rvalid = 0;
    @(posedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
